crubit_ctrl: RTL
================

// Module: crubit_ctrl
// PURPOSE
//   Sequencer/arbiter for the TIPI card's 4-bit CRU bit register.
//   Synchronises the asynchronous TI CRU write strobe into the card clock domain.
//   Decodes the CRU address against cru_base and applies single-bit writes.
//   Shares the register with a host-side (Pi) masked-write requester; serves CRU readback.
// PARAMETERS
//   SYNC_STAGES  2        flops per synchroniser on ti_cru_clk/ti_cru_out/ti_memen/addr (>=2)
//   CRU_PAGE     4'b0001  required value of addr[0:3] (CRU space >>1 page 0x1xxx)
// PORTS
//   clk          in   1   card clock; all state on its rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   cru_base     in   4   card CRU base select, compared to addr[4:7]
//   ti_cru_clk   in   1   TI CRU write strobe, async, active low
//   ti_memen     in   1   TI memory enable, async, active low; CRU cycle only while high
//   addr         in   15  TI address [0:14], bit 0 = MSB
//   ti_cru_out   in   1   TI CRU write data, async
//   ti_cru_in    out  1   CRU readback bit, registered
//   bits         out  4   CRU bit register [0:3]
//   host_req     in   1   host masked-write request, level
//   host_mask    in   4   host write mask [0:3], 1 = bit written
//   host_data    in   4   host write data [0:3]
//   host_ack     out  1   one-cycle pulse: host write applied
//   ti_busy      out  1   high while FSM is in TI_WR or HOLD
// BEHAVIOUR
//   Reset: bits=0, ti_cru_in=0, host_ack=0, ti_busy=0, FSM=IDLE, strobe syncs=1 (inactive).
//   Decode hit: addr[0:3]==CRU_PAGE && addr[4:7]==cru_base && addr[8:12]==0; idx=addr[13:14].
//   Edge: strobe_fall = sync'd ti_cru_clk previous 1, current 0; all inputs use sync'd copies.
//   FSM IDLE: strobe_fall && memen_s && hit -> TI_WR, latch idx and data;
//     strobe_fall without hit/memen -> HOLD (ignored);
//     else host_req -> HOST_WR.
//   TI_WR (1 cycle): bits[idx]<=data -> HOLD.  Visible 1 clk after edge detect.
//   HOST_WR (1 cycle): bits <= (bits & ~host_mask) | (host_data & host_mask); host_ack=1 -> IDLE.
//   HOLD: wait for sync'd ti_cru_clk==1 -> IDLE; exactly one write per strobe, however long low.
//   Simultaneous TI edge and host_req in IDLE: TI wins; host serviced on first free IDLE cycle.
//   host_req still high after ack: one more write after >=1 IDLE cycle; requester drops it on ack.
//   host_mask==0: ack still issued, bits unchanged.
//   ti_cru_in <= hit ? bits[idx] : 0, every clk from sync'd addr; SYNC_STAGES+1 clk latency.
//   Reset mid-operation: immediate async clear; strobe low at release gives no edge.
//   No write until high seen.
// CONFIGURATION
//   CRUBIT_HOST_IRQ_EN defined: adds outputs host_irq (1) and input host_irq_clr (1).
//     host_irq sets in any TI_WR that changes bits[idx]; clears on host_irq_clr pulse.
//     Set wins over simultaneous clear; reset 0.
//   Undefined: ports absent, no IRQ logic; all other behaviour identical.
// STRUCTURE
//   Package crubit_pkg: CRU_PAGE default, FSM state enum (IDLE, TI_WR, HOST_WR, HOLD),
//     idx width constant (2), decode function cru_hit(addr, base).
//   Sub-module crubit_sync: SYNC_STAGES-deep reset-able synchroniser, parameterised width/reset value.
//     Instantiated for strobe (reset 1) and for addr/data/memen bus (reset 0).
// TESTING
//   1 cru_base=0, addr=15'h0800..0803 in turn, ti_cru_out=1, strobe low 4 clk each -> bits 1000,1100,1110,1111.
//   2 cru_base=4'h2, addr=15'h0800 strobe -> bits unchanged, no write, ti_busy pulses (HOLD only).
//   3 strobe held low 20 clk, data toggled mid-pulse -> single write with value at edge.
//   4 host_req with mask=4'b0101, data=0 on bits=1111 -> bits=1010, host_ack 1 clk.
//   5 strobe edge and host_req in same clk -> TI write first, host_ack later; both applied.
//   6 rst_n low during HOLD with strobe low; release, strobe rises -> bits=0, no write; IRQ low if enabled.

Source files
------------

// File: rtl/crubit_pkg.sv
// crubit_pkg: shared constants, FSM states and CRU address decode for crubit_ctrl.
package crubit_pkg;
    localparam logic [3:0] CRU_PAGE_DFLT = 4'b0001;
    localparam int IDX_W = 2;
    typedef enum logic [1:0] {IDLE, TI_WR, HOST_WR, HOLD} state_e;
    function automatic logic cru_hit(input logic [0:14] a, input logic [3:0] base, input logic [3:0] page);
        return (a[0:3] == page) && (a[4:7] == base) && (a[8:12] == 5'd0);
    endfunction
endpackage

// File: rtl/crubit_sync.sv
// crubit_sync: STAGES-deep synchroniser with async active-low reset to RST_VAL.
module crubit_sync #(
    parameter int           W       = 1,
    parameter int           STAGES  = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] stage_q [STAGES];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end
    assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/crubit_ctrl.sv
// crubit_ctrl: TIPI CRU bit register sequencer arbitrating TI CRU writes and host masked writes.
// Optional host interrupt on TI bit change is enabled by defining CRUBIT_HOST_IRQ_EN.
module crubit_ctrl
    import crubit_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] CRU_PAGE    = CRU_PAGE_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cru_base,
    input  logic        ti_cru_clk,
    input  logic        ti_memen,
    input  logic [0:14] addr,
    input  logic        ti_cru_out,
    output logic        ti_cru_in,
    output logic [0:3]  bits,
    input  logic        host_req,
    input  logic [0:3]  host_mask,
    input  logic [0:3]  host_data,
    output logic        host_ack,
`ifdef CRUBIT_HOST_IRQ_EN
    output logic        host_irq,
    input  logic        host_irq_clr,
`endif
    output logic        ti_busy
);
    logic strobe_s, valid_s, memen_s, data_s, hit, fall;
    logic [0:14] addr_s;
    logic [17:0] bus_s;
    logic [IDX_W-1:0] idx_s, idx_q, idx_d;
    state_e state_q, state_d;
    logic [0:3] bits_q, bits_d;
    logic armed_q, armed_d, data_q, data_d, cru_in_q, ack_q;

    crubit_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_strobe (
        .clk(clk), .rst_n(rst_n), .d_i(ti_cru_clk), .q_o(strobe_s)
    );
    // valid travels with the bus so a strobe held low across reset release is never taken as an edge
    crubit_sync #(.W(18), .STAGES(SYNC_STAGES), .RST_VAL(18'd0)) u_sync_bus (
        .clk(clk), .rst_n(rst_n), .d_i({1'b1, ti_memen, ti_cru_out, addr}), .q_o(bus_s)
    );
    assign {valid_s, memen_s, data_s, addr_s} = bus_s;
    assign idx_s = addr_s[13:14];
    assign hit = cru_hit(addr_s, cru_base, CRU_PAGE);
    assign fall = armed_q && !strobe_s;

    always_comb begin
        state_d = state_q;
        bits_d = bits_q;
        idx_d = idx_q;
        data_d = data_q;
        armed_d = (valid_s && strobe_s) ? 1'b1 : armed_q;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = (memen_s && hit) ? TI_WR : HOLD;
                    idx_d = idx_s;
                    data_d = data_s;
                    armed_d = 1'b0;
                end else if (host_req && !ack_q) begin
                    state_d = HOST_WR;
                end
            end
            TI_WR: begin
                bits_d[idx_q] = data_q;
                state_d = HOLD;
            end
            HOST_WR: begin
                bits_d = (bits_q & ~host_mask) | (host_data & host_mask);
                state_d = IDLE;
            end
            HOLD: state_d = strobe_s ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bits_q <= '0;
            idx_q <= '0;
            data_q <= 1'b0;
            armed_q <= 1'b0;
            cru_in_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q <= bits_d;
            idx_q <= idx_d;
            data_q <= data_d;
            armed_q <= armed_d;
            cru_in_q <= hit && bits_q[idx_s];
            ack_q <= (state_q == HOST_WR);
        end
    end

    assign bits = bits_q;
    assign ti_cru_in = cru_in_q;
    assign host_ack = ack_q;
    assign ti_busy = (state_q == TI_WR) || (state_q == HOLD);

`ifdef CRUBIT_HOST_IRQ_EN
    logic irq_q, irq_set;
    assign irq_set = (state_q == TI_WR) && (bits_q[idx_q] != data_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else irq_q <= irq_set ? 1'b1 : host_irq_clr ? 1'b0 : irq_q;
    end
    assign host_irq = irq_q;
`endif
endmodule
